// File: rtl/whack_game_core.sv
// Whack-a-mole game core: mole selection, show/gap timing, hit/miss detection, saturating scoring.
// Latency: a button edge sampled at a clock edge updates score, hit_pulse and the LEDs at that same edge (visible next cycle).
// Backpressure: none; buttons and start are level inputs that are edge-detected internally, so no input is ever stalled.
//
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   start        level; a rising edge starts a game from IDLE or GAMEOVER
//   button       synchronised/debounced buttons, bit i pairs with mole i
//   mole_led     one-hot lit mole while a mole is shown, otherwise zero
//   score        saturating hit count
//   misses       saturating timeout count
//   round_cnt    moles shown so far in this game
//   hit_pulse    one-cycle pulse on a hit
//   miss_pulse   one-cycle pulse on a timeout
//   game_over    high once the last round has finished
//
// Optional build macro WRONG_PENALTY_EN: a wrong-button edge while a mole is
// shown decrements score (floor 0) instead of being ignored.
module whack_game_core #(
  parameter int         N_MOLES    = 8,
  parameter int         SCORE_W    = 6,
  parameter int         MOLE_TICKS = 50_000_000,
  parameter int         GAP_TICKS  = 10_000_000,
  parameter int         ROUNDS     = 30,
  parameter logic [7:0] SEED       = 8'h01
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [N_MOLES-1:0]           button,
  output logic [N_MOLES-1:0]           mole_led,
  output logic [SCORE_W-1:0]           score,
  output logic [SCORE_W-1:0]           misses,
  output logic [$clog2(ROUNDS+1)-1:0]  round_cnt,
  output logic                         hit_pulse,
  output logic                         miss_pulse,
  output logic                         game_over
);

  localparam int IW   = $clog2(N_MOLES);
  localparam int RW   = $clog2(ROUNDS + 1);
  localparam int TMAX = (MOLE_TICKS > GAP_TICKS) ? MOLE_TICKS : GAP_TICKS;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TICKS - 1);
  localparam logic [TW-1:0] MOLE_LAST = TW'(MOLE_TICKS - 1);
  localparam logic [RW-1:0] LAST_RND  = RW'(ROUNDS);
  localparam logic [IW:0]   NM_EXT    = (IW + 1)'(N_MOLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GAP,
    ST_SHOW,
    ST_GAMEOVER
  } state_t;

  state_t               state, state_n;
  logic [TW-1:0]        timer, timer_n;
  logic [7:0]           lfsr;
  logic [N_MOLES-1:0]   button_q;
  logic                 start_q;
  logic [IW-1:0]        mole_idx, idx_n;
  logic [SCORE_W-1:0]   score_n, misses_n;
  logic [RW-1:0]        round_n;
  logic                 hit_n, miss_n;

  logic [N_MOLES-1:0]   btn_edge;
  logic                 start_edge;
  logic                 hit;
  logic [N_MOLES-1:0]   mole_onehot;
  logic [IW:0]          raw_idx;
  logic [IW-1:0]        lfsr_idx;
`ifdef WRONG_PENALTY_EN
  logic                 wrong;
`endif

  assign btn_edge    = button & ~button_q;
  assign start_edge  = start & ~start_q;
  assign mole_onehot = N_MOLES'(1) << mole_idx;
  assign hit         = btn_edge[mole_idx];

  // Fold the low LFSR bits into range; one subtraction is enough because
  // the raw value is below 2^IW <= 2*N_MOLES.
  assign raw_idx  = {1'b0, lfsr[IW-1:0]};
  assign lfsr_idx = (raw_idx >= NM_EXT) ? IW'(raw_idx - NM_EXT) : lfsr[IW-1:0];

  assign mole_led  = (state == ST_SHOW) ? mole_onehot : '0;
  assign game_over = (state == ST_GAMEOVER);

`ifdef WRONG_PENALTY_EN
  assign wrong = |(btn_edge & ~mole_onehot);
`endif

  always_comb begin
    state_n  = state;
    timer_n  = timer;
    idx_n    = mole_idx;
    score_n  = score;
    misses_n = misses;
    round_n  = round_cnt;
    hit_n    = 1'b0;
    miss_n   = 1'b0;

    unique case (state)
      ST_IDLE, ST_GAMEOVER: begin
        if (start_edge) begin
          score_n  = '0;
          misses_n = '0;
          round_n  = '0;
          timer_n  = '0;
          state_n  = ST_GAP;
        end
      end

      ST_GAP: begin
        if (timer == GAP_LAST) begin
          idx_n   = lfsr_idx;
          round_n = round_cnt + RW'(1);
          timer_n = '0;
          state_n = ST_SHOW;
        end else begin
          timer_n = timer + TW'(1);
        end
      end

      ST_SHOW: begin
        // A correct press beats a simultaneous timeout or wrong press.
        if (hit) begin
          if (score != '1) score_n = score + SCORE_W'(1);
          hit_n   = 1'b1;
          timer_n = '0;
          state_n = (round_cnt == LAST_RND) ? ST_GAMEOVER : ST_GAP;
        end else begin
`ifdef WRONG_PENALTY_EN
          if (wrong && (score != '0)) score_n = score - SCORE_W'(1);
`endif
          if (timer == MOLE_LAST) begin
            if (misses != '1) misses_n = misses + SCORE_W'(1);
            miss_n  = 1'b1;
            timer_n = '0;
            state_n = (round_cnt == LAST_RND) ? ST_GAMEOVER : ST_GAP;
          end else begin
            timer_n = timer + TW'(1);
          end
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      timer      <= '0;
      lfsr       <= SEED;
      button_q   <= '0;
      start_q    <= 1'b0;
      mole_idx   <= '0;
      score      <= '0;
      misses     <= '0;
      round_cnt  <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      button_q   <= button;
      start_q    <= start;
      mole_idx   <= idx_n;
      score      <= score_n;
      misses     <= misses_n;
      round_cnt  <= round_n;
      hit_pulse  <= hit_n;
      miss_pulse <= miss_n;
    end
  end

endmodule

// File: tb/tb_whack_game_core.sv
// Directed bench for whack_game_core: instance A uses the reference game
// parameters, instance B shares its stimulus but has a 2-bit score and more
// rounds so saturation and held/wrong button cases can be exercised.
module tb_whack_game_core;

  localparam int         NM   = 4;
  localparam logic [7:0] SEED = 8'h01;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [NM-1:0] button;

  logic [NM-1:0] mole_led_a, mole_led_b;
  logic [5:0]    score_a, misses_a;
  logic [1:0]    score_b, misses_b;
  logic [2:0]    round_a;
  logic [3:0]    round_b;
  logic          hit_a, miss_a, go_a, hit_b, miss_b, go_b;

  logic [7:0]    m_lfsr = SEED;
  int            n_checks = 0;
  int            n_errors = 0;
  int            idx, n, k, w;

  always #5 clk = ~clk;

  whack_game_core #(
    .N_MOLES(NM), .SCORE_W(6), .MOLE_TICKS(10), .GAP_TICKS(3), .ROUNDS(4), .SEED(SEED)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start), .button(button),
    .mole_led(mole_led_a), .score(score_a), .misses(misses_a), .round_cnt(round_a),
    .hit_pulse(hit_a), .miss_pulse(miss_a), .game_over(go_a)
  );

  whack_game_core #(
    .N_MOLES(NM), .SCORE_W(2), .MOLE_TICKS(10), .GAP_TICKS(3), .ROUNDS(8), .SEED(SEED)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start), .button(button),
    .mole_led(mole_led_b), .score(score_b), .misses(misses_b), .round_cnt(round_b),
    .hit_pulse(hit_b), .miss_pulse(miss_b), .game_over(go_b)
  );

  // Reference LFSR from the published recurrence.
  always @(posedge clk) begin
    if (reset) m_lfsr <= SEED;
    else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  function automatic int idx_of(input logic [7:0] l);
    int v;
    v = int'(l[1:0]);
    if (v >= NM) v = v - NM;
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until a mole lights; idx is the prediction taken just before the
  // lighting edge, cnt the number of ticks spent.
  task automatic wait_mole(input bit use_b, output int pidx, output int cnt);
    int  p;
    bit  done;
    done = 0;
    cnt  = 0;
    pidx = 0;
    while (!done && cnt < 20) begin
      p = idx_of(m_lfsr);
      tick();
      cnt++;
      if ((use_b ? mole_led_b : mole_led_a) != '0) begin
        done = 1;
        pidx = p;
      end
    end
  endtask

  task automatic wait_miss(input bit use_b, output int cnt);
    bit done;
    done = 0;
    cnt  = 0;
    while (!done && cnt < 30) begin
      tick();
      cnt++;
      if (use_b ? miss_b : miss_a) done = 1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic hit_now(input int i);
    button = NM'(1) << i;
    tick();
    button = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    button = '0;

    // Reset state and idling without start.
    do_reset();
    check("rst_led",    32'(mole_led_a), 0);
    check("rst_score",  32'(score_a), 0);
    check("rst_misses", 32'(misses_a), 0);
    check("rst_round",  32'(round_a), 0);
    check("rst_pulses", {hit_a, miss_a, go_a}, 0);
    repeat (20) tick();
    check("idle_led",   32'(mole_led_a), 0);
    check("idle_state", {round_a, go_a}, 0);

    // Round 1: three gap cycles, then hit two cycles into SHOW.
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_mole(0, idx, n);
    check("gap_len",   n, 3);
    check("mole_pos",  32'(mole_led_a), 32'(1 << idx));
    check("round1",    32'(round_a), 1);
    tick();
    hit_now(idx);
    check("hit_pulse", hit_a, 1);
    check("hit_score", 32'(score_a), 1);
    check("hit_led",   32'(mole_led_a), 0);
    tick();
    check("hit_once",  hit_a, 0);

    // Round 2: no press, start edge mid-SHOW must be ignored.
    wait_mole(0, idx, n);
    check("gap_len2",  n, 2);
    start = 1'b1;
    wait_miss(0, k);
    check("miss_time", k, 10);
    check("miss_cnt",  32'(misses_a), 1);
    check("miss_keep", 32'(score_a), 1);
    check("miss_rnd",  32'(round_a), 2);
    start = 1'b0;
    tick();
    check("miss_once", miss_a, 0);

    // Round 3: press on the last SHOW cycle, hit beats timeout.
    wait_mole(0, idx, n);
    repeat (9) tick();
    hit_now(idx);
    check("late_hit",  {hit_a, miss_a}, 2'b10);
    check("late_scr",  32'(score_a), 2);
    tick();
    check("late_nomiss", miss_a, 0);

    // Round 4: timeout ends the game.
    wait_mole(0, idx, n);
    check("round4",    32'(round_a), 4);
    wait_miss(0, k);
    check("go_set",    go_a, 1);
    check("go_misses", 32'(misses_a), 2);
    repeat (10) tick();
    button = '1;
    tick();
    button = '0;
    repeat (39) tick();
    check("go_hold",   {score_a, misses_a, round_a, go_a}, {6'd2, 6'd2, 3'd4, 1'b1});
    check("go_led",    32'(mole_led_a), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart",   {score_a, misses_a, round_a, go_a}, 0);

    // Instance B: saturation, held button, wrong button.
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 1; r <= 5; r++) begin
      wait_mole(1, idx, n);
      hit_now(idx);
      check("sat_score", 32'(score_b), (r < 3) ? r : 3);
      tick();
    end
    button = '1;
    wait_mole(1, idx, n);
    wait_miss(1, k);
    check("held_miss", k, 10);
    check("held_score", 32'(score_b), 3);
    check("held_misses", 32'(misses_b), 1);
    button = '0;
    tick();
    wait_mole(1, idx, n);
    w = (idx + 1) % NM;
    button = NM'(1) << w;
    tick();
    button = '0;
`ifdef WRONG_PENALTY_EN
    check("wrong_score", 32'(score_b), 2);
`else
    check("wrong_score", 32'(score_b), 3);
`endif
    check("wrong_lit",  32'(mole_led_b), 32'(1 << idx));
    check("wrong_nohit", hit_b, 0);
    wait_miss(1, k);
    check("wrong_timer", k, 9);
    check("wrong_misses", 32'(misses_b), 2);

    // Reset in the middle of SHOW with score 2.
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 0; r < 2; r++) begin
      wait_mole(0, idx, n);
      hit_now(idx);
      tick();
    end
    check("pre_rst_score", 32'(score_a), 2);
    wait_mole(0, idx, n);
    tick();
    reset  = 1'b1;
    button = NM'(1) << idx;
    tick();
    check("mid_rst", {mole_led_a, score_a, misses_a, round_a, hit_a, miss_a, go_a}, 0);
    check("mid_lfsr", 32'(dut_a.lfsr), 32'(SEED));
    reset  = 1'b0;
    button = '0;
    tick();
    check("post_rst_pulses", {hit_a, miss_a}, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_mole(0, idx, n);
    check("post_rst_gap", n, 3);
    check("post_rst_mole", 32'(mole_led_a), 32'(1 << idx));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/whack_game_core.md
Name: whack_game_core

Overview:
Parametrised successor to the fixed 8-LED whack-a-mole top. It integrates mole selection, timing, hit/miss detection and scoring in one sequential core. Adds a start/round/game-over state machine, a configurable mole count, configurable on-time and gap-time, miss counting, and saturating scores. Outputs feed the LED bank and the existing binary-to-7-segment display path (score bus).

Parameters:
N_MOLES, 8, number of mole LEDs/buttons; must be >= 2.
SCORE_W, 6, score and miss counter width; both saturate at 2^SCORE_W-1.
MOLE_TICKS, 50_000_000, clock cycles a mole stays lit (SHOW duration); must be >= 1.
GAP_TICKS, 10_000_000, clock cycles of dark gap between moles; must be >= 1.
ROUNDS, 30, moles per game; must be >= 1.
SEED, 8'h01, LFSR reset value; must be nonzero.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  level; rising edge starts a game from IDLE or GAMEOVER
button  in  N_MOLES  already-synchronised, debounced buttons; bit i pairs with mole i
mole_led  out  N_MOLES  one-hot lit mole in SHOW, else all zero
score  out  SCORE_W  hit count
misses  out  SCORE_W  timeout count
round_cnt  out  $clog2(ROUNDS+1)  moles shown so far in this game
hit_pulse  out  1  one-cycle pulse on a hit
miss_pulse  out  1  one-cycle pulse on a timeout
game_over  out  1  high in GAMEOVER

Behaviour:
- Reset: state=IDLE; all outputs 0; timers 0; LFSR=SEED; button_q/start_q=0.
- Edge detect: button_q and start_q registered every cycle. edge = x & ~x_q. A button held across SHOW entry does not count.
- LFSR: 8-bit Fibonacci, free-running every cycle in all states, never zero. next = {l[6:0], l[7]^l[5]^l[4]^l[3]}.
- Mole index: idx = l[IW-1:0], IW = $clog2(N_MOLES); if idx >= N_MOLES, use idx-N_MOLES (a single subtraction suffices).
- IDLE: LEDs off. On a start edge: score, misses and round_cnt cleared; go to GAP with timer=0.
- GAP: LEDs off. When the timer reaches GAP_TICKS-1: latch idx from the current LFSR, increment round_cnt, timer=0, go to SHOW.
- SHOW: mole_led = 1<<idx. Transitions:
  - Edge on button[idx]: hit. score+1 (saturating), hit_pulse=1 next cycle, leave SHOW.
  - Otherwise, timer reaches MOLE_TICKS-1: miss. misses+1 (saturating), miss_pulse=1, leave SHOW.
  - Leaving SHOW: go to GAMEOVER if round_cnt==ROUNDS, else GAP.
- Latency: button edge sampled at edge n; at edge n+1 score, hit_pulse and LED clear are all visible.
- Simultaneous events:
  - Hit in the same cycle as timeout: hit wins, no miss.
  - Correct and wrong buttons in the same cycle: hit.
  - Without the optional feature, wrong-button edges are ignored.
- start edge in GAP/SHOW: ignored.
- GAMEOVER: game_over=1, LEDs off, score/misses/round_cnt held. A start edge clears the counters and goes to GAP.
- Reset mid-operation (any state): immediate return to reset values on the next edge; no pulses are generated.
- Pulses are registered and last exactly one cycle.

Optional Feature:
WRONG_PENALTY_EN
- Defined: in SHOW, an edge on any button other than idx, with no edge on button[idx] that cycle, decrements score (floors at 0). The mole stays lit and the timer continues.
- Undefined: wrong presses have no effect.

Test Plan:
Use N_MOLES=4, MOLE_TICKS=10, GAP_TICKS=3, ROUNDS=4, SCORE_W=6, SEED=8'h01. The bench model tracks the LFSR to predict idx.
1. Assert reset 2 cycles, then release -> all outputs 0, mole_led=0; hold 20 cycles without start -> still 0.
2. start edge; after 3 GAP cycles mole_led one-hot at predicted idx, round_cnt=1; press button[idx] 2 cycles into SHOW -> next cycle hit_pulse=1, score=1, mole_led=0.
3. Next mole, no press -> after exactly 10 SHOW cycles miss_pulse=1 for one cycle, misses=1, score unchanged.
4. Press button[idx] on the 10th SHOW cycle -> hit, score+1, no miss_pulse. Complete round 4 -> game_over=1, score/misses held for 50 cycles. Then a start edge -> counters 0, game_over=0.
5. SCORE_W=2, 5 hits -> score stays 3. Button held high before SHOW entry and never released -> no hit, miss at timeout. Wrong button pressed -> score unchanged (with WRONG_PENALTY_EN: score-1, floor 0).
6. Assert reset during SHOW with score=2 -> next cycle state IDLE, mole_led=0, score=0, no pulses, LFSR back to 8'h01.
